bsg_gateway_channel_tx: RTL and testbench
=========================================

BSG_GATEWAY_CHANNEL_TX -- requirements
Module: bsg_gateway_channel_tx

Interface
REQ-001 Parameters SHALL be: reset_periods_p, 16, output-clock periods reset_o is held high after reset; train_periods_p, 32, output-clock periods of training pattern before RUN.
REQ-002 clk_i  in  1  core clock; single clock domain.
REQ-003 reset_i  in  1  reset; synchronous and active-high.
REQ-004 data_i  in  4x8  per-channel words; channel 0..3 maps to a..d.
REQ-005 valid_i  in  4  per-channel word valid.
REQ-006 ready_o  out  4  per-channel accept.
REQ-007 clk_output_o  out  4  source-synchronous channel clocks, to the output delay stage.
REQ-008 data_a_output_o .. data_d_output_o  out  8 each  channel data, to the output delay stage.
REQ-009 valid_output_o  out  4  channel valid, to the output delay stage.
REQ-010 reset_o  out  1  downstream reset, to the output delay stage.

Function
REQ-011 A phase flop SHALL toggle every clk_i cycle in all states; all four clk_output_o bits SHALL equal phase.
REQ-012 The launch edge SHALL be the clk_i edge where phase goes 1->0; data/valid outputs SHALL update only on launch edges, giving one cycle of setup to the clk_output_o rise.
REQ-013 The FSM SHALL have states RESET_HOLD, TRAIN and RUN, with exactly one state active.
REQ-014 RESET_HOLD: reset_o=1, valid_output_o=0, data=0x00; after reset_periods_p launch edges, go to TRAIN.
REQ-015 TRAIN: reset_o=0, valid_output_o=0; data on all channels SHALL alternate 0xA5, 0x5A, starting with 0xA5, per launch edge.
REQ-016 TRAIN SHALL go to RUN on the launch edge that ends train_periods_p periods.
REQ-017 RUN SHALL be terminal until reset_i.
REQ-018 Each channel SHALL have a one-entry buffer; ready_o[c] = RUN && (!full[c] || launch edge this cycle).
REQ-019 A word SHALL be enqueued when valid_i[c] && ready_o[c].
REQ-020 On a launch edge in RUN, a full buffer SHALL drive its word with valid_output_o[c]=1 and clear full.
REQ-021 On a launch edge in RUN, an empty buffer SHALL drive valid_output_o[c]=0 and hold the last data.
REQ-022 If an enqueue and a launch coincide, the buffered word SHALL launch and the new word SHALL occupy the buffer: no loss and no bubble.
REQ-023 Peak throughput SHALL be one word per channel per two clk_i cycles; channels SHALL be fully independent.
REQ-024 Period counters SHALL be sized clog2(max(reset_periods_p, train_periods_p)+1) and SHALL saturate, never wrap.

Reset
REQ-025 Reset outputs: state=RESET_HOLD, phase=0, clk_output_o=0, reset_o=1, valid_output_o=0, all data outputs=0x00, buffers empty, ready_o=0, counters=0.
REQ-026 reset_i asserted mid-operation SHALL discard buffered words and return to RESET_HOLD the next cycle, with no partial word launched.

Structure
REQ-027 Package bsg_gateway_pkg SHALL hold the FSM state enum and the training constants 0xA5/0x5A.
REQ-028 Sub-module bsg_gateway_tx_lane SHALL hold one channel's buffer and output registers; it SHALL be instantiated four times.
REQ-029 The FSM, phase flop and counters SHALL be shared in the top level.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to *_output_o.

Verification
REQ-031 Scenario: release reset, defaults -> reset_o high 32 clk_i cycles, then 64 cycles of A5/5A training with valid low, then ready_o=0xF.
REQ-032 Scenario: channel b streams 0x01..0x10 with valid_i held high -> 16 words on data_b at one per 2 cycles, in order, valid_b continuous, other channels valid low.
REQ-033 Scenario: channel a sends a word only after launch edges where the buffer was already full -> every word appears exactly once, exercising the simultaneous enqueue/launch case.
REQ-034 Scenario: reset_i pulsed for 1 cycle while channel d holds 0x7E -> 0x7E never appears, outputs return to their reset values, and the sequence restarts.
REQ-035 Scenario: random valid_i on all channels for 10k cycles -> scoreboard matches per channel, and data changes only on launch edges.
REQ-036 Scenario: reset_periods_p=1, train_periods_p=1 -> RUN reached after 4 clk_i cycles with no counter wrap.

Source files
------------

// File: rtl/bsg_gateway_pkg.sv
// Shared types and constants for the gateway transmit channel: the
// one-hot FSM state encoding, the training words and the channel geometry.
package bsg_gateway_pkg;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 8;

    // Training words alternate on every launch while the link trains.
    localparam logic [WORD_W-1:0] TRAIN_WORD_0 = 8'hA5;
    localparam logic [WORD_W-1:0] TRAIN_WORD_1 = 8'h5A;

    // One-hot encoding so exactly one state bit is ever set.
    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'b001,
        ST_TRAIN      = 3'b010,
        ST_RUN        = 3'b100
    } state_e;

    // Training word for a given period index parity.
    function automatic logic [WORD_W-1:0] train_word(input logic i_odd);
        return i_odd ? TRAIN_WORD_1 : TRAIN_WORD_0;
    endfunction

endpackage

// File: rtl/bsg_gateway_tx_lane.sv
// One transmit lane: a single-entry skid buffer in front of the launch
// registers that drive one source-synchronous channel.
module bsg_gateway_tx_lane
    import bsg_gateway_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_launch,
    input  logic              i_run,
    input  state_e            i_next_state,
    input  logic [WORD_W-1:0] i_train_word,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid
);

    logic              r_full;
    logic [WORD_W-1:0] r_buf;
    logic [WORD_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              w_enq;

    // A launch frees the buffer in the same cycle, so a full buffer can
    // still accept a word exactly when it is about to be launched.
    assign o_ready = i_run && (!r_full || i_launch);
    assign w_enq   = i_valid && o_ready;

    // Buffer occupancy: filled on enqueue, drained by a launch in RUN.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full <= 1'b0;
        end else if (w_enq) begin
            r_full <= 1'b1;
        end else if (i_launch && i_run) begin
            r_full <= 1'b0;
        end
    end

    // Buffer payload capture.
    // NOTE: payload has no reset; r_full alone decides whether it is meaningful.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_buf <= i_data;
        end
    end

    // Launch registers: change only on launch edges, content set by the
    // state the link is entering on that edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else if (i_launch) begin
            case (i_next_state)
                ST_TRAIN: begin
                    r_data_out  <= i_train_word;
                    r_valid_out <= 1'b0;
                end
                ST_RUN: begin
                    r_valid_out <= r_full;
                    if (r_full) begin
                        r_data_out <= r_buf;
                    end
                end
                default: begin
                    r_data_out  <= '0;
                    r_valid_out <= 1'b0;
                end
            endcase
        end
    end

    assign o_data  = r_data_out;
    assign o_valid = r_valid_out;

endmodule

// File: rtl/bsg_gateway_channel_tx.sv
// Four-channel source-synchronous transmitter: shared phase flop, link
// bring-up FSM (reset hold, training, run) and four buffered lanes.
module bsg_gateway_channel_tx
    import bsg_gateway_pkg::*;
#(
    parameter int reset_periods_p = 16,
    parameter int train_periods_p = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_CH-1:0][WORD_W-1:0]  data_i,
    input  logic [NUM_CH-1:0]              valid_i,
    output logic [NUM_CH-1:0]              ready_o,
    output logic [NUM_CH-1:0]              clk_output_o,
    output logic [WORD_W-1:0]              data_a_output_o,
    output logic [WORD_W-1:0]              data_b_output_o,
    output logic [WORD_W-1:0]              data_c_output_o,
    output logic [WORD_W-1:0]              data_d_output_o,
    output logic [NUM_CH-1:0]              valid_output_o,
    output logic                           reset_o
);

    localparam int MAX_PERIODS_LP = (reset_periods_p > train_periods_p) ?
                                    reset_periods_p : train_periods_p;
    localparam int CNT_W_LP = $clog2(MAX_PERIODS_LP + 1);
    localparam logic [CNT_W_LP-1:0] RESET_LAST_LP = CNT_W_LP'(reset_periods_p - 1);
    localparam logic [CNT_W_LP-1:0] TRAIN_LAST_LP = CNT_W_LP'(train_periods_p - 1);
    localparam logic [CNT_W_LP-1:0] CNT_SAT_LP    = CNT_W_LP'(MAX_PERIODS_LP);

    logic                            r_phase;
    state_e                          r_state;
    state_e                          w_state_next;
    logic [CNT_W_LP-1:0]             r_count;
    logic [CNT_W_LP-1:0]             w_count_next;
    logic [CNT_W_LP-1:0]             w_count_inc;
    logic                            r_reset_o;
    logic                            w_launch;
    logic                            w_run;
    logic [WORD_W-1:0]               w_train_word;
    logic [NUM_CH-1:0]               w_ready;
    logic [NUM_CH-1:0][WORD_W-1:0]   w_data_out;
    logic [NUM_CH-1:0]               w_valid_out;

    // The launch edge is the one where phase falls, i.e. phase is high now.
    assign w_launch    = r_phase;
    assign w_run       = (r_state == ST_RUN);
    assign w_count_inc = (r_count == CNT_SAT_LP) ? r_count : r_count + CNT_W_LP'(1);

    // Free-running half-rate phase; it is the forwarded channel clock.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    // Next-state and period-count logic; everything advances on launch edges.
    // NOTE: defaults first so every path assigns every output and no latch forms.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        if (w_launch) begin
            case (r_state)
                ST_RESET_HOLD: begin
                    if (r_count >= RESET_LAST_LP) begin
                        w_state_next = ST_TRAIN;
                        w_count_next = '0;
                    end else begin
                        w_count_next = w_count_inc;
                    end
                end
                ST_TRAIN: begin
                    if (r_count >= TRAIN_LAST_LP) begin
                        w_state_next = ST_RUN;
                        w_count_next = '0;
                    end else begin
                        w_count_next = w_count_inc;
                    end
                end
                ST_RUN: begin
                    w_state_next = ST_RUN;
                end
                default: begin
                    w_state_next = ST_RESET_HOLD;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // Training period index parity selects the word, so period 0 sends 0xA5.
    assign w_train_word = train_word(w_count_next[0]);

    // Bring-up FSM with its registered downstream reset output.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_RESET_HOLD;
            r_count   <= '0;
            r_reset_o <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_launch) begin
                r_reset_o <= (w_state_next == ST_RESET_HOLD);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        bsg_gateway_tx_lane u_lane (
            .i_clk        (clk_i),
            .i_reset      (reset_i),
            .i_launch     (w_launch),
            .i_run        (w_run),
            .i_next_state (w_state_next),
            .i_train_word (w_train_word),
            .i_data       (data_i[c]),
            .i_valid      (valid_i[c]),
            .o_ready      (w_ready[c]),
            .o_data       (w_data_out[c]),
            .o_valid      (w_valid_out[c])
        );
    end

    assign ready_o         = w_ready;
    assign clk_output_o    = {NUM_CH{r_phase}};
    assign data_a_output_o = w_data_out[0];
    assign data_b_output_o = w_data_out[1];
    assign data_c_output_o = w_data_out[2];
    assign data_d_output_o = w_data_out[3];
    assign valid_output_o  = w_valid_out;
    assign reset_o         = r_reset_o;

endmodule

// File: tb/tb_bsg_gateway_channel_tx.sv
// Bench for bsg_gateway_channel_tx: directed bring-up, streaming, coincident
// enqueue/launch, mid-run reset and random traffic, with a queue scoreboard.
module tb_bsg_gateway_channel_tx;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [3:0][7:0] data_i = '0;
    logic [3:0]      valid_i = '0;
    logic [3:0]      ready_o, clk_out, vout;
    logic [7:0]      da, db, dc, dd;
    logic            rst_out;
    logic [3:0][7:0] dout;

    // Second instance with minimum bring-up lengths.
    logic [3:0][7:0] data_i2 = '0;
    logic [3:0]      valid_i2 = '0;
    logic [3:0]      ready2, clk_out2, vout2;
    logic [7:0]      da2, db2, dc2, dd2;
    logic            rst_out2;

    always #5 clk = ~clk;

    bsg_gateway_channel_tx dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .clk_output_o(clk_out),
        .data_a_output_o(da), .data_b_output_o(db),
        .data_c_output_o(dc), .data_d_output_o(dd),
        .valid_output_o(vout), .reset_o(rst_out)
    );

    bsg_gateway_channel_tx #(.reset_periods_p(1), .train_periods_p(1)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i2), .valid_i(valid_i2),
        .ready_o(ready2), .clk_output_o(clk_out2),
        .data_a_output_o(da2), .data_b_output_o(db2),
        .data_c_output_o(dc2), .data_d_output_o(dd2),
        .valid_output_o(vout2), .reset_o(rst_out2)
    );

    assign dout = {dd, dc, db, da};

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference phase model: launch happened at the last edge when phase was high.
    logic m_phase = 1'b0;
    logic m_launched = 1'b0;
    logic m_rst = 1'b1;
    always @(posedge clk) begin
        m_phase    <= reset_i ? 1'b0 : ~m_phase;
        m_launched <= !reset_i && m_phase;
        m_rst      <= reset_i;
    end

    // Scoreboard
    logic [7:0] exp_q [4][$];
    int         cyc = 0;
    bit         rec_b = 0;
    int         b_times[$];
    logic [35:0] prev_out;
    bit         prev_ok = 0;
    logic [7:0] mon_word;

    // Monitor: pops on launched words, checks outputs hold between launches.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (m_launched) begin
            for (int c = 0; c < 4; c++) begin
                if (exp_q[c].size() == 0) begin
                    check($sformatf("idle_valid_ch%0d", c), vout[c], 1'b0);
                end else if (vout[c]) begin
                    mon_word = exp_q[c].pop_front();
                    check($sformatf("data_ch%0d", c), dout[c], mon_word);
                    if (c == 1 && rec_b) b_times.push_back(cyc);
                end
            end
        end else if (!m_rst && prev_ok) begin
            check("hold_between_launches", {vout, dout}, prev_out);
        end
        prev_out = {vout, dout};
        prev_ok  = 1;
    end

    // Apply one cycle of inputs (caller sits at a negedge); record accepted words.
    task automatic drive(input logic [3:0] v, input logic [3:0][7:0] d, output logic [3:0] acc);
        valid_i = v;
        data_i  = d;
        acc     = v & ready_o;
        for (int c = 0; c < 4; c++) if (acc[c]) exp_q[c].push_back(d[c]);
    endtask

    task automatic idle(input int n);
        logic [3:0] acc;
        repeat (n) begin
            @(negedge clk);
            drive('0, '0, acc);
        end
    endtask

    // Wait (bounded) for a negedge where the next edge is not a launch.
    task automatic align_no_launch();
        logic [3:0] acc;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            drive('0, '0, acc);
            if (!m_phase) break;
        end
        check("align_phase", m_phase, 1'b0);
    endtask

    // Hold reset, check reset values, release and check the bring-up sequence.
    task automatic reset_and_check(input int n_hold);
        logic [7:0] e_data;
        valid_i = '0;
        reset_i = 1'b1;
        repeat (n_hold) @(negedge clk);
        check("rst_reset_o", rst_out, 1'b1);
        check("rst_clk_out", clk_out, 4'h0);
        check("rst_valid", vout, 4'h0);
        check("rst_data", dout, 32'h0);
        check("rst_ready", ready_o, 4'h0);
        check("rst_reset_o_2", rst_out2, 1'b1);
        check("rst_data_2", {dd2, dc2, db2, da2}, 32'h0);
        reset_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k < 31) e_data = 8'h00;
            else if (k < 95) e_data = ((((k - 31) / 2) % 2) == 0) ? 8'hA5 : 8'h5A;
            else e_data = 8'h5A;
            check("up_reset_o", rst_out, (k < 31) ? 1'b1 : 1'b0);
            check("up_clk_out", clk_out, ((k % 2) == 0) ? 4'hF : 4'h0);
            check("up_data", dout, {4{e_data}});
            check("up_valid", vout, 4'h0);
            check("up_ready", ready_o, (k >= 95) ? 4'hF : 4'h0);
            check("up_reset_o_2", rst_out2, (k < 1) ? 1'b1 : 1'b0);
            check("up_data_2", {dd2, dc2, db2, da2}, {4{(k < 1) ? 8'h00 : 8'hA5}});
            check("up_valid_2", vout2, 4'h0);
            check("up_ready_2", ready2, (k >= 3) ? 4'hF : 4'h0);
        end
    endtask

    initial begin
        logic [3:0]      acc;
        logic [3:0][7:0] d;
        int              word;
        int              sent;

        // Bring-up from power-on reset.
        reset_and_check(3);

        // Channel b streams 0x01..0x10 with valid held high.
        b_times.delete();
        rec_b = 1;
        word  = 1;
        for (int t = 0; t < 100 && word <= 16; t++) begin
            @(negedge clk);
            d    = '0;
            d[1] = word[7:0];
            drive(4'b0010, d, acc);
            if (acc[1]) word++;
        end
        check("stream_accepted", word, 17);
        idle(6);
        rec_b = 0;
        check("stream_b_count", b_times.size(), 16);
        for (int i = 1; i < b_times.size(); i++)
            check("stream_b_gap", b_times[i] - b_times[i-1], 2);

        // Channel a: words offered only when the buffer is full and a launch is due.
        align_no_launch();
        d    = '0;
        d[0] = 8'h31;
        check("coinc_fill_ready", ready_o[0], 1'b1);
        drive(4'b0001, d, acc);
        sent = 1;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (m_phase) begin
                check("coinc_ready_launch", ready_o[0], 1'b1);
                d    = '0;
                d[0] = 8'h31 + 8'(sent);
                drive(4'b0001, d, acc);
                sent++;
            end else begin
                check("coinc_ready_full", ready_o[0], 1'b0);
                drive('0, '0, acc);
            end
        end
        idle(6);
        check("coinc_words_sent", sent, 8);
        check("coinc_drained", exp_q[0].size(), 0);

        // Reset pulse while channel d holds 0x7E: the word must be dropped.
        align_no_launch();
        check("rst_fill_ready", ready_o[3], 1'b1);
        valid_i    = 4'b1000;
        data_i     = '0;
        data_i[3]  = 8'h7E;
        @(negedge clk);
        reset_and_check(1);
        idle(4);
        check("rst_no_7e", dd, 8'h5A);

        // Random traffic on all channels.
        for (int t = 0; t < 10000; t++) begin
            @(negedge clk);
            d = {$urandom, 32'h0} >> 32;
            drive(4'($urandom), d, acc);
        end
        idle(6);
        for (int c = 0; c < 4; c++)
            check($sformatf("random_drained_ch%0d", c), exp_q[c].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
